ysyx_exu_muldiv_rs: RTL
=======================

Name: ysyx_exu_muldiv_rs

Overview:
- Reservation station directly upstream of ysyx_exu_mul. Holds up to RS_SIZE dispatched RV32M ops and snoops the CDB for missing operands.
- Issues one ready op at a time into the mul/div unit. The unit has no ready/cancel, so this block tracks the op in flight itself.
- Captures the unit's result into a tagged output register drained with a valid/ready handshake toward writeback/CDB arbitration.

Parameters:
- XLEN, `YSYX_XLEN, operand/result width.
- RS_SIZE, 4, number of station entries (≥2).
- TAG_W, 4, ROB/destination tag width.

Ports:
- clock in 1 system clock
- reset in 1 synchronous, active-high reset
- flush in 1 kill all held and in-flight work
- in_valid in 1 dispatch request
- in_ready out 1 free entry available
- in_op in 5 `YSYX_ALU_* M-extension opcode
- in_vj, in_vk in XLEN operand values (valid when matching q*_busy=0)
- in_qj_busy, in_qk_busy in 1 operand still pending
- in_qj, in_qk in TAG_W producer tags of pending operands
- in_dest in TAG_W destination tag
- cdb_valid in 1 broadcast valid
- cdb_tag in TAG_W broadcast tag
- cdb_data in XLEN broadcast value
- mul_a, mul_b out XLEN operands to unit
- mul_op out 5 opcode to unit
- mul_valid out 1 one-cycle issue pulse (unit in_valid)
- mul_r in XLEN unit result
- mul_rvalid in 1 unit out_valid
- out_valid out 1 result held
- out_ready in 1 consumer accepts
- out_tag out TAG_W destination tag of held result
- out_r out XLEN held result

Behaviour:
- Reset: all entries free. inflight=0, kill=0. out_valid=0, out_tag=0, out_r=0, mul_valid=0, mul_a=mul_b=0, mul_op=0. in_ready=0 while reset is high.
- in_ready = !flush && any entry free (combinational). Dispatch when in_valid && in_ready: lowest-index free entry takes the op.
- Dispatch-cycle wakeup: if cdb_valid && cdb_tag==in_qj && in_qj_busy, the entry stores cdb_data with busy=0. Same for k.
- Held entries: each busy operand whose tag matches a valid CDB captures cdb_data and clears busy that cycle.
- Entry ready = valid && !qj_busy && !qk_busy. A CDB value arriving this cycle does not make the entry ready until next cycle.
- Issue condition: !inflight && !out_valid && !flush && some entry ready.
  - Pick the lowest-index ready entry.
  - Register mul_a/mul_b/mul_op, pulse mul_valid for exactly 1 cycle.
  - Free the entry; set inflight=1 and inflight_tag=dest.
  - At most one op in the unit; issue latency from ready is 1 cycle.
- Completion: mul_rvalid && inflight && !kill sets out_valid=1, out_r=mul_r, out_tag=inflight_tag, and clears inflight.
  - mul_rvalid with inflight=0 is ignored (stale pulse after reset).
- Drain: out_valid && out_ready clears out_valid next cycle. Out register is 1-deep; issue stalls while it is full. out_r/out_tag stay stable while out_valid && !out_ready.
- Flush:
  - Same cycle: clears all entries and out_valid; dispatch and issue are suppressed.
  - If inflight, set kill=1. Keep inflight=1 (blocks issue) until mul_rvalid, then drop the result and clear inflight and kill.
  - Flush coinciding with mul_rvalid drops that result.
- Simultaneous drain and completion: impossible by construction, since issue requires !out_valid.
- Reset mid-operation: everything clears. A later mul_rvalid is ignored per the rule above.
- Unit latency is variable: no cycle count is assumed, only mul_rvalid.
- Result values are produced by the unit, never altered here.

Decomposition:
- Shared package ysyx_rs_pkg:
  - rs_entry_t struct {valid, op[4:0], vj, vk, qj_busy, qj, qk_busy, qk, dest}
  - RS_SIZE/TAG_W defaults
  - Opcodes stay the existing `YSYX_ALU_* macros from ysyx.svh.
- One natural sub-module: ysyx_rs_pick, a parameterised lowest-index priority picker (request vector → one-hot grant + index + any). Used twice: free-slot select and ready select.

Test Plan:
- Dispatch MUL vj=7 vk=6 (no pending), unit returns 42 → mul_valid 1 cycle after dispatch with a=7 b=6; out_valid with out_r=42, out_tag=in_dest.
- Dispatch DIV qj_busy tag=3, vk=2; next cycle CDB tag=3 data=100 → entry ready the cycle after; issue a=100 b=2; out_r=50.
- Fill 4 entries, out_ready=0 → in_ready=0 on the 5th. First result is held stable. Second issue occurs only after out_ready handshake; 4 results drain in index order.
- Issue REM, assert flush while in flight, dispatch a MULHU → MULHU waits until stale mul_rvalid. Stale result never appears on out_valid; MULHU result appears later.
- Dispatch with cdb_valid tag matching in_qj the same cycle → operand captured, no hang; result correct (e.g. MULH -2×3 → 0xFFFFFFFF).
- Assert reset with op in flight and out_valid=1 → all outputs 0 next cycle; later mul_rvalid ignored; in_ready=1 after reset deasserts.

Source files
------------

// File: rtl/ysyx_rs_pkg.sv
// Shared types and defaults for the mul/div reservation station.
// Falls back to a 32-bit datapath when the core-wide XLEN macro is absent.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_rs_pkg;

    localparam int RS_XLEN     = `YSYX_XLEN;
    localparam int RS_SIZE_DEF = 4;
    localparam int RS_TAG_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [4:0]          op;
        logic [RS_XLEN-1:0]  vj;
        logic [RS_XLEN-1:0]  vk;
        logic                qj_busy;
        logic [RS_TAG_W-1:0] qj;
        logic                qk_busy;
        logic [RS_TAG_W-1:0] qk;
        logic [RS_TAG_W-1:0] dest;
    } rs_entry_t;

    // Capture a matching CDB broadcast into whichever operands are still pending.
    function automatic rs_entry_t rs_snoop(input rs_entry_t e, input logic cv,
                                           input logic [RS_TAG_W-1:0] ct,
                                           input logic [RS_XLEN-1:0] cd);
        rs_entry_t r;
        r = e;
        if (e.valid && cv) begin
            if (e.qj_busy && e.qj == ct) begin
                r.vj      = cd;
                r.qj_busy = 1'b0;
            end
            if (e.qk_busy && e.qk == ct) begin
                r.vk      = cd;
                r.qk_busy = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_rs_pick.sv
// Lowest-index priority picker: request vector to one-hot grant, index and any.
module ysyx_rs_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk downwards so the lowest requesting index is the last to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_exu_muldiv_rs.sv
// Reservation station feeding the single-op mul/div unit; tracks the op in flight
// and holds one tagged result for writeback.
module ysyx_exu_muldiv_rs
    import ysyx_rs_pkg::*;
#(
    parameter int XLEN    = RS_XLEN,
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int TAG_W   = RS_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic             in_qj_busy,
    input  logic             in_qk_busy,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [TAG_W-1:0] in_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    output logic [4:0]       mul_op,
    output logic             mul_valid,
    input  logic [XLEN-1:0]  mul_r,
    input  logic             mul_rvalid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_r
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];
    rs_entry_t new_entry;
    rs_entry_t sel_entry;

    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  out_r_q, out_r_d;
    logic             mul_valid_q, mul_valid_d;
    logic [XLEN-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [4:0]       mul_op_q, mul_op_d;

    logic [RS_SIZE-1:0] free_req, rdy_req, free_gnt, rdy_gnt;
    logic [IDX_W-1:0]   free_idx, rdy_idx;
    logic               free_any, rdy_any;
    logic               dispatch, issue, complete;
    logic [IDX_W-1:0]   unused_free_idx;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_req[i] = !entries_q[i].valid;
            rdy_req[i]  = entries_q[i].valid && !entries_q[i].qj_busy && !entries_q[i].qk_busy;
        end
    end

    ysyx_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
        .req(free_req), .gnt(free_gnt), .idx(free_idx), .any(free_any)
    );

    ysyx_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_rdy_pick (
        .req(rdy_req), .gnt(rdy_gnt), .idx(rdy_idx), .any(rdy_any)
    );

    assign unused_free_idx = free_idx;
    assign in_ready  = !reset && !flush && free_any;
    assign dispatch  = in_valid && in_ready;
    assign issue     = !inflight_q && !out_valid_q && !flush && rdy_any;
    assign complete  = mul_rvalid && inflight_q;
    assign sel_entry = entries_q[rdy_idx];

    always_comb begin
        new_entry = rs_snoop('{valid: 1'b1, op: in_op, vj: in_vj, vk: in_vk,
                               qj_busy: in_qj_busy, qj: in_qj,
                               qk_busy: in_qk_busy, qk: in_qk, dest: in_dest},
                             cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = rs_snoop(entries_q[i], cdb_valid, cdb_tag, cdb_data);
            if (issue && rdy_gnt[i]) entries_d[i].valid = 1'b0;
            if (dispatch && free_gnt[i]) entries_d[i] = new_entry;
            if (flush) entries_d[i].valid = 1'b0;
        end

        mul_valid_d    = issue;
        mul_a_d        = issue ? sel_entry.vj : mul_a_q;
        mul_b_d        = issue ? sel_entry.vk : mul_b_q;
        mul_op_d       = issue ? sel_entry.op : mul_op_q;

        inflight_d     = inflight_q;
        kill_d         = kill_q;
        inflight_tag_d = inflight_tag_q;
        if (complete) begin
            inflight_d = 1'b0;
            kill_d     = 1'b0;
        end else if (flush && inflight_q) begin
            // The unit cannot be cancelled: stay blocked until its result drains.
            kill_d = 1'b1;
        end
        if (issue) begin
            inflight_d     = 1'b1;
            inflight_tag_d = sel_entry.dest;
        end

        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_tag_d   = out_tag_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (complete && !kill_q && !flush) begin
            out_valid_d = 1'b1;
            out_r_d     = mul_r;
            out_tag_d   = inflight_tag_q;
        end
        if (flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) entries_q[i].valid <= 1'b0;
            inflight_q     <= 1'b0;
            kill_q         <= 1'b0;
            inflight_tag_q <= '0;
            out_valid_q    <= 1'b0;
            out_tag_q      <= '0;
            out_r_q        <= '0;
            mul_valid_q    <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_op_q       <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
            inflight_q     <= inflight_d;
            kill_q         <= kill_d;
            inflight_tag_q <= inflight_tag_d;
            out_valid_q    <= out_valid_d;
            out_tag_q      <= out_tag_d;
            out_r_q        <= out_r_d;
            mul_valid_q    <= mul_valid_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_op_q       <= mul_op_d;
        end
    end

    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_op    = mul_op_q;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_r     = out_r_q;

endmodule
